// File: rtl/lif_scheduler.sv
// lif_scheduler
//   Time-multiplexed leaky integrate-and-fire engine. One step request
//   snapshots all input currents, then walks the neurons one per cycle
//   through a single shared update datapath, and finishes with a done pulse
//   that publishes the spike flags of that timestep.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   step       one-cycle timestep request (ignored unless idle)
//   current    per-neuron 8-bit input current, neuron i at [8i+7:8i]
//   busy       high from the accepting edge until the done edge
//   done       one-cycle pulse, NEURONS+1 cycles after the accepting edge
//   spike_vec  spike flags of the last completed timestep
//   rd_idx     readback neuron select
//   rd_state   combinational membrane state of neuron rd_idx
module lif_scheduler #(
  parameter int NEURONS    = 4,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  localparam int IW = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      step,
  input  logic [NEURONS-1:0][7:0]   current,
  output logic                      busy,
  output logic                      done,
  output logic [NEURONS-1:0]        spike_vec,
  input  logic [IW-1:0]             rd_idx,
  output logic [7:0]                rd_state
);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} fsm_t;

  localparam logic [8:0]    TH      = 9'(THRESH);
  localparam logic [RW-1:0] REF_LD  = RW'(REFRAC);
  localparam logic [IW-1:0] LAST_IX = IW'(NEURONS - 1);

  fsm_t                     state_q, state_d;
  logic [IW-1:0]            idx;
  logic [NEURONS-1:0][7:0]  snap;
  logic [NEURONS-1:0][7:0]  mem_st;
  logic [NEURONS-1:0][RW-1:0] refrac;
  logic [NEURONS-1:0]       spike_acc;

  // shared update datapath, operating on neuron idx
  logic [7:0]    cur_st, cur_snap, sat;
  logic [RW-1:0] cur_ref;
  logic [8:0]    sum9;
  logic          fire, in_refrac, last;

  assign cur_st    = mem_st[idx];
  assign cur_snap  = snap[idx];
  assign cur_ref   = refrac[idx];
  assign in_refrac = (cur_ref != '0);
  assign sum9      = {1'b0, cur_snap} + {1'b0, cur_st >> LEAK_SHIFT};
  assign sat       = sum9[8] ? 8'hFF : sum9[7:0];
  assign fire      = ({1'b0, sat} >= TH);
  assign last      = (idx == LAST_IX);

  assign rd_state  = mem_st[rd_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step) state_d = UPDATE;
      UPDATE:  if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      snap      <= '0;
      mem_st    <= '0;
      refrac    <= '0;
      spike_acc <= '0;
      spike_vec <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (step) begin
          snap <= current;
          idx  <= '0;
          busy <= 1'b1;
        end
        UPDATE: begin
          if (in_refrac) begin
            // refractory: input is dropped, neuron held at rest
            mem_st[idx]    <= '0;
            refrac[idx]    <= cur_ref - 1'b1;
            spike_acc[idx] <= 1'b0;
          end else if (fire) begin
            mem_st[idx]    <= '0;
            refrac[idx]    <= REF_LD;
            spike_acc[idx] <= 1'b1;
          end else begin
            mem_st[idx]    <= sat;
            spike_acc[idx] <= 1'b0;
          end
          idx <= last ? '0 : idx + 1'b1;
        end
        DONE: begin
          done      <= 1'b1;
          spike_vec <= spike_acc;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
module tb_lif_scheduler;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             step = 1'b0;
  logic [N-1:0][7:0] current = '0;
  logic             busy, done;
  logic [N-1:0]     spike_vec;
  logic [1:0]       rd_idx = '0;
  logic [7:0]       rd_state;

  int n_chk = 0;
  int n_fail = 0;

  lif_scheduler #(.NEURONS(N), .THRESH(200), .LEAK_SHIFT(1), .REFRAC(2)) dut (
    .clk(clk), .reset_n(reset_n), .step(step), .current(current),
    .busy(busy), .done(done), .spike_vec(spike_vec),
    .rd_idx(rd_idx), .rd_state(rd_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;   // reset before applying this vector
    logic [31:0] cur;
    logic [3:0]  spk;
    logic [31:0] st;    // expected states, neuron i at [8i+7:8i]
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    step = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // waits up to 20 edges for done; returns edges counted, 99 on timeout
  task automatic wait_done(output int lat);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic check_states(input string name, input logic [31:0] exp);
    for (int i = 0; i < N; i++) begin
      rd_idx = 2'(i);
      #1;
      check(name, 32'(rd_state), 32'(exp[8*i +: 8]));
    end
  endtask

  task automatic do_step(input logic [31:0] cur);
    int lat;
    @(negedge clk);
    current = cur;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done(lat);
    check("latency", 32'(lat), 32'(N + 1));
  endtask

  initial begin
    int lat, ndone;

    // leak/refractory walk on neuron0 (150: 150, spike, refr, refr, 150)
    vecs[0]  = '{1'b1, 32'h0000_0096, 4'b0000, 32'h0000_0096};
    vecs[1]  = '{1'b0, 32'h0000_0096, 4'b0001, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0000_0096, 4'b0000, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0000_0096, 4'b0000, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0000_0096, 4'b0000, 32'h0000_0096};
    // saturation on neuron1: 190, then 255+95 -> 255 >= 200
    vecs[5]  = '{1'b1, 32'h0000_BE00, 4'b0000, 32'h0000_BE00};
    vecs[6]  = '{1'b0, 32'h0000_FF00, 4'b0010, 32'h0000_0000};
    // all at threshold: fire, two refractory steps, fire again
    vecs[7]  = '{1'b1, 32'hC8C8_C8C8, 4'b1111, 32'h0000_0000};
    vecs[8]  = '{1'b0, 32'hC8C8_C8C8, 4'b0000, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'hC8C8_C8C8, 4'b0000, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'hC8C8_C8C8, 4'b1111, 32'h0000_0000};

    // reset state
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_spike", 32'(spike_vec), 32'd0);
    check_states("rst_state", 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].rst) apply_reset();
      do_step(vecs[v].cur);
      check($sformatf("v%0d_spike", v), 32'(spike_vec), 32'(vecs[v].spk));
      check_states($sformatf("v%0d_state", v), vecs[v].st);
      // spike_vec holds between pulses
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_hold", v), 32'(spike_vec), 32'(vecs[v].spk));
    end

    // second step two cycles after an accepted one is dropped
    apply_reset();
    @(negedge clk);
    current = 32'h0000_0096;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    ndone = 0;
    lat = 99;
    for (int k = 2; k <= 14; k++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; if (lat == 99) lat = k; end
    end
    check("busy_step_dones", 32'(ndone), 32'd1);
    check("busy_step_lat", 32'(lat), 32'(N + 1));
    check("busy_step_idle", 32'(busy), 32'd0);
    check_states("busy_step_state", 32'h0000_0096);

    // step held during the DONE cycle is dropped as well
    @(negedge clk);
    current = 32'h0000_0000;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (N) @(posedge clk);
    @(negedge clk);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    check("done_step_pulse", 32'(done), 32'd1);
    check("done_step_busy0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("done_step_busy1", 32'(busy), 32'd0);
    check("done_step_nodone", 32'(done), 32'd0);
    check_states("done_step_state", 32'h0000_004B);

    // current changed mid-update: snapshot wins
    apply_reset();
    @(negedge clk);
    current = 32'h1010_1010;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    current = 32'hFFFF_FFFF;
    wait_done(lat);
    check("snap_lat", 32'(lat), 32'(N + 1));
    check("snap_spike", 32'(spike_vec), 32'd0);
    check_states("snap_state", 32'h1010_1010);
    current = '0;

    // reset while walking neuron index 2, then restart on first clean edge
    apply_reset();
    @(negedge clk);
    current = 32'h6464_6464;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_spike", 32'(spike_vec), 32'd0);
    check_states("midrst_state", 32'd0);
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_nodone", 32'(ndone), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    check("postrst_accept", 32'(busy), 32'd1);
    wait_done(lat);
    check("postrst_lat", 32'(lat), 32'(N + 1));
    check("postrst_spike", 32'(spike_vec), 32'd0);
    check_states("postrst_state", 32'h6464_6464);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
